led_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_prescaler.sv | 32 +++
 rtl/led_sequencer.sv | 170 +++++++++++++++++
 tb/tb_led_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the LED sequencer.
//   Instruction layout: opcode = [3:0], operand = [7:4].
//   Opcodes 0x6..0xF are undefined; they run as NOP and pulse the illegal flag.
package seq_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned INSTR_W   = 8;
    localparam int unsigned OPERAND_W = INSTR_W - OPCODE_W;

    localparam logic [OPCODE_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_WAIT   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_OFF    = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ON     = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_TOGGLE = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_HALT   = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage : seq_pkg

// File: rtl/seq_prescaler.sv
// seq_prescaler: free-running tick-enable generator for WAIT timing.
//   CLK     system clock
//   RST     asynchronous active-high reset
//   clr     synchronous clear (wins over en)
//   en      count enable
//   tick_c  high while enabled and the counter is all ones (combinational)
module seq_prescaler #(
    parameter int unsigned PRESCALE_BITS = 24
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    logic [PRESCALE_BITS-1:0] cnt;

    // Counter: wraps naturally, so a tick occurs once every 2^PRESCALE_BITS enabled cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PRESCALE_BITS'(1);
        end
    end

    assign tick_c = en & (&cnt);

endmodule : seq_prescaler

// File: rtl/led_sequencer.sv
// led_sequencer: steps a packed program of 8-bit instructions to drive the board LED.
//   CLK      system clock (16 MHz)
//   RST      asynchronous active-high reset
//   run      level; 1 executes the program, 0 returns to IDLE (also releases HALT)
//   prog     instruction slots, slot i = prog[8i+7:8i], slot 0 first
//   led      LED drive
//   pc       index of the current slot
//   busy     high in FETCH/EXEC/WAIT
//   halted   high in HALT
//   illegal  one-cycle pulse when an undefined opcode executes
// Build option: define SEQ_LOOP_EN to wrap from the last slot back to slot 0
// instead of halting.
module led_sequencer
    import seq_pkg::*;
#(
    parameter  int unsigned PROGRAM_LEN   = 4,
    parameter  int unsigned PRESCALE_BITS = 24,
    localparam int unsigned PC_W          = (PROGRAM_LEN > 1) ? $clog2(PROGRAM_LEN) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         run,
    input  logic [INSTR_W*PROGRAM_LEN-1:0] prog,
    output logic                         led,
    output logic [PC_W-1:0]              pc,
    output logic                         busy,
    output logic                         halted,
    output logic                         illegal
);

    state_t                 state;
    logic [INSTR_W-1:0]     ir;
    logic [OPERAND_W-1:0]   wait_cnt;

    logic [INSTR_W-1:0]     slot_c;
    logic [OPCODE_W-1:0]    op_c;
    logic [OPERAND_W-1:0]   operand_c;
    logic                   tick_c;
    logic                   ps_clr_c;
    logic                   ps_en_c;
    logic                   adv_c;
    logic                   last_slot_c;

    // Instruction fields and slot selection
    always_comb begin
        slot_c    = prog[INSTR_W*32'(pc) +: INSTR_W];
        op_c      = ir[OPCODE_W-1:0];
        operand_c = ir[INSTR_W-1:OPCODE_W];
    end

    // Prescaler control: cleared on WAIT entry and on leaving for IDLE
    always_comb begin
        ps_clr_c = 1'b0;
        ps_en_c  = 1'b0;
        if (state != ST_IDLE && !run) begin
            ps_clr_c = 1'b1;
        end else if (state == ST_EXEC && op_c == OP_WAIT) begin
            ps_clr_c = 1'b1;
        end
        if (state == ST_WAIT) begin
            ps_en_c = 1'b1;
        end
    end

    seq_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (ps_clr_c),
        .en     (ps_en_c),
        .tick_c (tick_c)
    );

    // Advance request: a finished non-WAIT/non-HALT EXEC, or the final WAIT tick
    always_comb begin
        adv_c       = 1'b0;
        last_slot_c = (pc == PC_W'(PROGRAM_LEN - 1));
        if (state == ST_EXEC && op_c != OP_WAIT && op_c != OP_HALT) begin
            adv_c = 1'b1;
        end else if (state == ST_WAIT && tick_c && wait_cnt == '0) begin
            adv_c = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            ir       <= '0;
            wait_cnt <= '0;
            led      <= 1'b0;
            pc       <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (state != ST_IDLE && !run) begin
                state  <= ST_IDLE;
                pc     <= '0;
                busy   <= 1'b0;
                halted <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pc <= '0;
                        if (run) begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        ir    <= slot_c;
                        state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        case (op_c)
                            OP_OFF:    led <= 1'b0;
                            OP_ON:     led <= 1'b1;
                            OP_TOGGLE: led <= ~led;
                            OP_WAIT: begin
                                wait_cnt <= operand_c;
                                state    <= ST_WAIT;
                            end
                            OP_HALT: begin
                                state  <= ST_HALT;
                                busy   <= 1'b0;
                                halted <= 1'b1;
                            end
                            default: begin
                                if (op_c > OP_HALT) begin
                                    illegal <= 1'b1;
                                end
                            end
                        endcase
                    end
                    ST_WAIT: begin
                        if (tick_c && wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - OPERAND_W'(1);
                        end
                    end
                    ST_HALT: begin
                        state <= ST_HALT;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase

                if (adv_c) begin
                    if (!last_slot_c) begin
                        pc    <= pc + PC_W'(1);
                        state <= ST_FETCH;
                    end else begin
`ifdef SEQ_LOOP_EN
                        pc    <= '0;
                        state <= ST_FETCH;
`else
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule : led_sequencer

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer (PROGRAM_LEN=4, PRESCALE_BITS=4).
// Stimulus pushes the expected {cycle, led, halted, illegal, pc} for every change of
// led/halted/illegal; a monitor pops and compares whenever one of those outputs changes.
module tb_led_sequencer;

    localparam int unsigned PLEN = 4;
    localparam int unsigned PBITS = 4;

    typedef struct packed {
        int unsigned cyc;
        logic        led;
        logic        halted;
        logic        illegal;
        logic [1:0]  pc;
    } ev_t;

    logic        CLK;
    logic        RST;
    logic        run;
    logic [31:0] prog;
    logic        led;
    logic [1:0]  pc;
    logic        busy;
    logic        halted;
    logic        illegal;

    int unsigned cyc;
    int          pass_cnt;
    int          total_cnt;
    ev_t         exp_q[$];
    ev_t         got_ev;
    ev_t         exp_ev;
    logic [2:0]  prev_obs;

    led_sequencer #(
        .PROGRAM_LEN   (PLEN),
        .PRESCALE_BITS (PBITS)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .run     (run),
        .prog    (prog),
        .led     (led),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        prev_obs  = 3'b000;
    end

    // Monitor: any change of led/halted/illegal is an event to match against the queue
    always @(negedge CLK) begin
        if ({led, halted, illegal} !== prev_obs) begin
            prev_obs = {led, halted, illegal};
            got_ev   = '{cyc: cyc, led: led, halted: halted, illegal: illegal, pc: pc};
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got cyc=%0d led=%b halted=%b illegal=%b pc=%0d, required no event",
                         got_ev.cyc, got_ev.led, got_ev.halted, got_ev.illegal, got_ev.pc);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev === exp_ev) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL event: got cyc=%0d led=%b halted=%b illegal=%b pc=%0d, required cyc=%0d led=%b halted=%b illegal=%b pc=%0d",
                             got_ev.cyc, got_ev.led, got_ev.halted, got_ev.illegal, got_ev.pc,
                             exp_ev.cyc, exp_ev.led, exp_ev.halted, exp_ev.illegal, exp_ev.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input int unsigned c, input logic l, input logic h,
                        input logic i, input logic [1:0] p);
        exp_q.push_back('{cyc: c, led: l, halted: h, illegal: i, pc: p});
    endtask

    task automatic start_run(input logic [31:0] p, output int unsigned t0);
        @(negedge CLK);
        prog = p;
        run  = 1'b1;
        t0   = cyc;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_led"},     32'(led),     32'd0);
        chk({tag, "_pc"},      32'(pc),      32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_halted"},  32'(halted),  32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned t2;

        RST  = 1'b1;
        run  = 1'b0;
        prog = 32'h0;
        repeat (2) @(negedge CLK);
        check_reset_now("por");
        RST = 1'b0;

        // ON, WAIT 0, OFF, HALT
        start_run(32'h05020103, t0);
        push(t0 + 3,  1'b1, 1'b0, 1'b0, 2'd1);
        push(t0 + 23, 1'b0, 1'b0, 1'b0, 2'd3);
        push(t0 + 25, 1'b0, 1'b1, 1'b0, 2'd3);
        wait_until(t0 + 10);
        chk("busy_in_wait", 32'(busy), 32'd1);
        wait_until(t0 + 30);
        chk("busy_in_halt", 32'(busy), 32'd0);
        chk("pc_in_halt",   32'(pc),   32'd3);
        run = 1'b0;
        t1  = cyc;
        push(t1 + 1, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_until(t1 + 3);

        // WAIT operand 3: 64 cycles in WAIT
        start_run(32'h05023103, t0);
        push(t0 + 3,  1'b1, 1'b0, 1'b0, 2'd1);
        push(t0 + 71, 1'b0, 1'b0, 1'b0, 2'd3);
        push(t0 + 73, 1'b0, 1'b1, 1'b0, 2'd3);
        wait_until(t0 + 76);
        run = 1'b0;
        t1  = cyc;
        push(t1 + 1, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_until(t1 + 3);

        // ON, WAIT 0, OFF, WAIT 0
        start_run(32'h01020103, t0);
        push(t0 + 3,  1'b1, 1'b0, 1'b0, 2'd1);
        push(t0 + 23, 1'b0, 1'b0, 1'b0, 2'd3);
`ifdef SEQ_LOOP_EN
        push(t0 + 43, 1'b1, 1'b0, 1'b0, 2'd1);
        push(t0 + 63, 1'b0, 1'b0, 1'b0, 2'd3);
        wait_until(t0 + 70);
        chk("loop_not_halted", 32'(halted), 32'd0);
        run = 1'b0;
        t1  = cyc;
`else
        push(t0 + 41, 1'b0, 1'b1, 1'b0, 2'd3);
        wait_until(t0 + 45);
        chk("end_pc_held", 32'(pc), 32'd3);
        run = 1'b0;
        t1  = cyc;
        push(t1 + 1, 1'b0, 1'b0, 1'b0, 2'd0);
`endif
        wait_until(t1 + 3);
        chk("idle_pc", 32'(pc), 32'd0);

        // Illegal opcode in slot 0, then ON, HALT
        start_run(32'h0505030F, t0);
        push(t0 + 3, 1'b0, 1'b0, 1'b1, 2'd1);
        push(t0 + 4, 1'b0, 1'b0, 1'b0, 2'd1);
        push(t0 + 5, 1'b1, 1'b0, 1'b0, 2'd2);
        push(t0 + 7, 1'b1, 1'b1, 1'b0, 2'd2);
        wait_until(t0 + 10);
        run = 1'b0;
        t1  = cyc;
        push(t1 + 1, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(t1 + 2);

        // Asynchronous reset between edges clears the retained led at once
        @(posedge CLK);
        #2;
        push(cyc, 1'b0, 1'b0, 1'b0, 2'd0);
        RST = 1'b1;
        #1;
        check_reset_now("async_rst");
        @(negedge CLK);
        RST = 1'b0;

        // Drop run mid-WAIT, then restart with a changed slot 0
        start_run(32'h05020103, t0);
        push(t0 + 3, 1'b1, 1'b0, 1'b0, 2'd1);
        wait_until(t0 + 10);
        run = 1'b0;
        @(posedge CLK);
        #1;
        chk("drop_pc",   32'(pc),   32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_led",  32'(led),  32'd1);
        start_run(32'h05020104, t2);
        push(t2 + 3, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_until(t2 + 4);
        chk("restart_busy", 32'(busy), 32'd1);

        // Reset asserted mid-WAIT with led high
        wait_until(t2 + 8);
        run = 1'b0;
        wait_until(t2 + 10);
        start_run(32'h05020103, t0);
        push(t0 + 3, 1'b1, 1'b0, 1'b0, 2'd1);
        wait_until(t0 + 12);
        @(posedge CLK);
        #2;
        push(cyc, 1'b0, 1'b0, 1'b0, 2'd0);
        RST = 1'b1;
        #1;
        check_reset_now("wait_rst");
        run = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_led_sequencer
